memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Purpose  : RV32I memory stage - load/store bus access with alignment and
//            timeout checking, writeback hand-off and branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    // upstream handshake from execute
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] aluout,
    input  logic [31:0] store_data,
    input  logic        bt,
    input  logic [31:0] branch_addr,
    // data memory
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    // writeback
    output logic        out_valid,
    input  logic        out_ready,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    // fetch redirect
    output logic        redirect_valid,
    output logic [31:0] redirect_addr
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    // Counter only needs to reach MAX_WAIT-1: the last waiting cycle exits.
    localparam int         c_CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [31:0]         r_addr;
    logic [1:0]          r_off;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic                r_is_load;
    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [31:0]         r_wb_data;
    logic                r_wb_en;
    logic                r_err;
    logic                r_redirect_valid;
    logic [31:0]         r_redirect_addr;
    logic [c_CNT_W-1:0]  r_wait_cnt;

    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [4:0]          w_rd;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_mem;
    logic                w_fmt_ok;
    logic                w_align_ok;
    logic                w_access_ok;
    logic                w_bad;
    logic [3:0]          w_st_be;
    logic [31:0]         w_st_wdata;
    logic                w_accept;
    logic                w_in_access;
    logic                w_in_resp;
    logic                w_wait_last;
    logic [7:0]          w_load_byte;
    logic [15:0]         w_load_half;
    logic [31:0]         w_load_data;

    assign w_opcode    = instruction[6:0];
    assign w_funct3    = instruction[14:12];
    assign w_rd        = instruction[11:7];
    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_mem    = w_is_load | w_is_store;
    assign w_access_ok = w_is_mem & w_fmt_ok & w_align_ok;
    assign w_bad       = w_is_mem & ~w_access_ok;

    assign w_in_access = (r_state == S_ACCESS);
    assign w_in_resp   = (r_state == S_RESP);
    assign w_accept    = in_valid & in_ready;
    assign w_wait_last = (r_wait_cnt == c_WAIT_LAST);

    // Size/alignment decode plus store lane steering; undefined funct3 stays !fmt_ok.
    always_comb begin
        w_fmt_ok   = 1'b0;
        w_align_ok = 1'b0;
        w_st_be    = 4'b0000;
        w_st_wdata = 32'h0000_0000;
        case (w_funct3)
            3'b000: begin
                w_fmt_ok   = 1'b1;
                w_align_ok = 1'b1;
                w_st_be    = 4'b0001 << aluout[1:0];
                w_st_wdata = {4{store_data[7:0]}};
            end
            3'b001: begin
                w_fmt_ok   = 1'b1;
                w_align_ok = ~aluout[0];
                w_st_be    = 4'b0011 << aluout[1:0];
                w_st_wdata = {2{store_data[15:0]}};
            end
            3'b010: begin
                w_fmt_ok   = 1'b1;
                w_align_ok = (aluout[1:0] == 2'b00);
                w_st_be    = 4'b1111;
                w_st_wdata = store_data;
            end
            3'b100: begin
                w_fmt_ok   = w_is_load;
                w_align_ok = 1'b1;
            end
            3'b101: begin
                w_fmt_ok   = w_is_load;
                w_align_ok = ~aluout[0];
            end
            default: begin
                w_fmt_ok   = 1'b0;
                w_align_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_load_byte = 8'h00;
        case (r_off)
            2'd0:    w_load_byte = mem_rdata[7:0];
            2'd1:    w_load_byte = mem_rdata[15:8];
            2'd2:    w_load_byte = mem_rdata[23:16];
            default: w_load_byte = mem_rdata[31:24];
        endcase
        w_load_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
            3'b100:  w_load_data = {24'h000000, w_load_byte};
            3'b001:  w_load_data = {{16{w_load_half[15]}}, w_load_half};
            3'b101:  w_load_data = {16'h0000, w_load_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = w_access_ok ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (mem_ready || w_wait_last) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr           <= 32'h0000_0000;
            r_off            <= 2'b00;
            r_funct3         <= 3'b000;
            r_rd             <= 5'd0;
            r_is_load        <= 1'b0;
            r_we             <= 1'b0;
            r_be             <= 4'b0000;
            r_wdata          <= 32'h0000_0000;
            r_wb_data        <= 32'h0000_0000;
            r_wb_en          <= 1'b0;
            r_err            <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_addr  <= 32'h0000_0000;
            r_wait_cnt       <= '0;
        end else begin
            r_redirect_valid <= w_accept & bt;
            if (w_accept) begin
                if (bt) begin
                    r_redirect_addr <= branch_addr;
                end
                r_addr     <= {aluout[31:2], 2'b00};
                r_off      <= aluout[1:0];
                r_funct3   <= w_funct3;
                r_rd       <= w_rd;
                r_is_load  <= w_is_load;
                r_we       <= w_is_store & w_access_ok;
                r_be       <= (w_is_store & w_access_ok) ? w_st_be : 4'b0000;
                r_wdata    <= (w_is_store & w_access_ok) ? w_st_wdata : 32'h0000_0000;
                r_wb_data  <= w_is_mem ? 32'h0000_0000 : aluout;
                r_wb_en    <= ~w_is_store & ~w_bad & (w_rd != 5'd0);
                r_err      <= w_bad;
                r_wait_cnt <= '0;
            end else if (w_in_access) begin
                if (mem_ready) begin
                    if (r_is_load) begin
                        r_wb_data <= w_load_data;
                    end
                end else if (w_wait_last) begin
                    // Bus timeout: abandon the access and report it.
                    r_err   <= 1'b1;
                    r_wb_en <= 1'b0;
                end else begin
                    r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign in_ready       = (r_state == S_IDLE);
    assign mem_req        = w_in_access;
    assign mem_we         = w_in_access & r_we;
    assign mem_be         = w_in_access ? r_be : 4'b0000;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign out_valid      = w_in_resp;
    assign wb_en          = w_in_resp & r_wb_en;
    assign err            = w_in_resp & r_err;
    assign wb_rd          = r_rd;
    assign wb_data        = r_wb_data;
    assign redirect_valid = r_redirect_valid;
    assign redirect_addr  = r_redirect_addr;

endmodule
`default_nettype wire
